// File: rtl/control_unit.sv
// Hardwired multi-cycle control unit: fetch T0-T2, execute T3-T5, absorbing HALT.
// Define CU_MEM_WAIT_EN to add mem_ready and let T1 stall on slow memory.
module control_unit #(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef CU_MEM_WAIT_EN
    input  logic                 mem_ready,
`endif
    input  logic [BITS-1:0]      IRVal,
    output logic [REGISTERS-1:0] GPRin,
    output logic [REGISTERS-1:0] GPRout,
    output logic                 PCin,
    output logic                 IRin,
    output logic                 RYin,
    output logic                 RZin,
    output logic                 MARin,
    output logic                 HILOin,
    output logic                 MDRin,
    output logic                 OUTPUTin,
    output logic                 Read,
    output logic                 Write,
    output logic                 INPUTout,
    output logic                 MDRout,
    output logic                 HILOout,
    output logic                 RZout,
    output logic                 PCout,
    output logic                 BAout,
    output logic                 IncPC,
    output logic                 ADD,
    output logic                 SUB,
    output logic                 MUL,
    output logic                 DIV,
    output logic                 SHR,
    output logic                 SHL,
    output logic                 ROR,
    output logic                 ROL,
    output logic                 AND,
    output logic                 OR,
    output logic                 NEGATE,
    output logic                 NOT,
    output logic                 run,
    output logic [31:0]          instr_count
);

    // state   | meaning
    // S_RESET | held in reset, all controls idle
    // S_T0    | PC -> MAR, PC+1 -> RZ, count fetch
    // S_T1    | memory read, RZ -> PC (stalls on mem_ready when enabled)
    // S_T2    | MDR -> IR
    // S_T3-T5 | execute steps, length depends on opcode class
    // S_HALT  | stopped until reset
    typedef enum logic [2:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
    } state_t;

    localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_SHR = 5'b00101,
                           OP_SHL = 5'b00110, OP_ROR = 5'b00111, OP_ROL = 5'b01000,
                           OP_AND = 5'b01001, OP_OR  = 5'b01010, OP_MUL = 5'b01110,
                           OP_DIV = 5'b01111, OP_NEG = 5'b10000, OP_NOT = 5'b10001,
                           OP_HLT = 5'b11010;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        mem_ok;
    logic        alu_en;
    logic [11:0] alu_vec;
    logic        is_bin, is_md, is_un, is_halt;
    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc;
    logic        unused_ir;

`ifdef CU_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    assign opcode    = IRVal[31:27];
    assign ra        = IRVal[26:23];
    assign rb        = IRVal[22:19];
    assign rc        = IRVal[18:15];
    assign unused_ir = ^IRVal;

    function automatic logic [REGISTERS-1:0] reg_sel(input logic [3:0] idx);
        reg_sel = '0;
        if (int'(idx) < REGISTERS) reg_sel[idx] = 1'b1;
    endfunction

    // ALU one-hot order: ADD SUB MUL DIV SHR SHL ROR ROL AND OR NEGATE NOT
    always_comb begin
        alu_vec = '0;
        is_bin  = 1'b0;
        is_md   = 1'b0;
        is_un   = 1'b0;
        is_halt = 1'b0;
        case (opcode)
            OP_ADD: begin alu_vec[11] = 1'b1; is_bin = 1'b1; end
            OP_SUB: begin alu_vec[10] = 1'b1; is_bin = 1'b1; end
            OP_MUL: begin alu_vec[9]  = 1'b1; is_md  = 1'b1; end
            OP_DIV: begin alu_vec[8]  = 1'b1; is_md  = 1'b1; end
            OP_SHR: begin alu_vec[7]  = 1'b1; is_bin = 1'b1; end
            OP_SHL: begin alu_vec[6]  = 1'b1; is_bin = 1'b1; end
            OP_ROR: begin alu_vec[5]  = 1'b1; is_bin = 1'b1; end
            OP_ROL: begin alu_vec[4]  = 1'b1; is_bin = 1'b1; end
            OP_AND: begin alu_vec[3]  = 1'b1; is_bin = 1'b1; end
            OP_OR:  begin alu_vec[2]  = 1'b1; is_bin = 1'b1; end
            OP_NEG: begin alu_vec[1]  = 1'b1; is_un  = 1'b1; end
            OP_NOT: begin alu_vec[0]  = 1'b1; is_un  = 1'b1; end
            OP_HLT: is_halt = 1'b1;
            default: ;
        endcase
    end

    assign {ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT} =
        alu_en ? alu_vec : 12'd0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        run      = 1'b0;
        alu_en   = 1'b0;
        GPRin    = '0;
        GPRout   = '0;
        PCin     = 1'b0;
        IRin     = 1'b0;
        RYin     = 1'b0;
        RZin     = 1'b0;
        MARin    = 1'b0;
        HILOin   = 1'b0;
        MDRin    = 1'b0;
        OUTPUTin = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        INPUTout = 1'b0;
        MDRout   = 1'b0;
        HILOout  = 1'b0;
        RZout    = 1'b0;
        PCout    = 1'b0;
        BAout    = 1'b0;
        IncPC    = 1'b0;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                run     = 1'b1;
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                RZin    = 1'b1;
                cnt_d   = cnt_q + 32'd1;
                state_d = S_T1;
            end
            S_T1: begin
                run   = 1'b1;
                Read  = 1'b1;
                MDRin = 1'b1;
                // PC may only load on the single cycle memory completes
                if (mem_ok) begin
                    RZout   = 1'b1;
                    PCin    = 1'b1;
                    state_d = S_T2;
                end
            end
            S_T2: begin
                run     = 1'b1;
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                run = 1'b1;
                if (is_bin || is_md) begin
                    GPRout  = reg_sel(rb);
                    RYin    = 1'b1;
                    state_d = S_T4;
                end else if (is_un) begin
                    GPRout  = reg_sel(rb);
                    alu_en  = 1'b1;
                    RZin    = 1'b1;
                    state_d = S_T4;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T4: begin
                run = 1'b1;
                if (is_un) begin
                    RZout   = 1'b1;
                    GPRin   = reg_sel(ra);
                    state_d = S_T0;
                end else begin
                    GPRout  = reg_sel(rc);
                    alu_en  = 1'b1;
                    RZin    = 1'b1;
                    state_d = S_T5;
                end
            end
            S_T5: begin
                run = 1'b1;
                if (is_md) begin
                    HILOin = 1'b1;
                end else begin
                    RZout = 1'b1;
                    GPRin = reg_sel(ra);
                end
                state_d = S_T0;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-cycle control-word expectations built from opcode class rules.
// Builds with or without CU_MEM_WAIT_EN.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IRVal;
`ifdef CU_MEM_WAIT_EN
    logic        mem_ready;
`endif
    logic [15:0] GPRin, GPRout;
    logic PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, OUTPUTin;
    logic Read, Write, INPUTout, MDRout, HILOout, RZout, PCout, BAout, IncPC;
    logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT;
    logic run;
    logic [31:0] instr_count;

    control_unit #(.BITS(32), .REGISTERS(16)) dut (
        .clk(clk), .reset(reset),
`ifdef CU_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .IRVal(IRVal), .GPRin(GPRin), .GPRout(GPRout),
        .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .MARin(MARin),
        .HILOin(HILOin), .MDRin(MDRin), .OUTPUTin(OUTPUTin),
        .Read(Read), .Write(Write), .INPUTout(INPUTout), .MDRout(MDRout),
        .HILOout(HILOout), .RZout(RZout), .PCout(PCout), .BAout(BAout), .IncPC(IncPC),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL),
        .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT),
        .run(run), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // loads: PCin IRin RYin RZin MARin HILOin MDRin OUTPUTin
    localparam logic [7:0] L_PC = 8'h80, L_IR = 8'h40, L_RY = 8'h20, L_RZ = 8'h10,
                           L_MAR = 8'h08, L_HILO = 8'h04, L_MDR = 8'h02;
    // bus: Read Write INPUTout MDRout HILOout RZout PCout BAout IncPC
    localparam logic [8:0] B_READ = 9'h100, B_MDR = 9'h020, B_RZ = 9'h008,
                           B_PC = 9'h004, B_INC = 9'h001;

    typedef struct {
        logic [63:0] v;
        bit          mr;
        bit          fetch;
        bit          load_ir;
    } cyc_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_cnt = 0;
    bit          wait_en;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] observed();
        return {2'b00, GPRin, GPRout,
                PCin, IRin, RYin, RZin, MARin, HILOin, MDRin, OUTPUTin,
                Read, Write, INPUTout, MDRout, HILOout, RZout, PCout, BAout, IncPC,
                ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, run};
    endfunction

    function automatic logic [63:0] mk(input logic [15:0] gin, input logic [15:0] gout,
                                       input logic [7:0] ld, input logic [8:0] bus,
                                       input logic [11:0] alu, input logic r);
        return {2'b00, gin, gout, ld, bus, alu, r};
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] i);
        return 16'd1 << i;
    endfunction

    // 0 nop, 1 binary, 2 mul/div, 3 unary, 4 halt; alu bit in ADD..NOT order
    function automatic int kind_of(input logic [4:0] op, output logic [11:0] alu);
        alu = 12'd0;
        case (op)
            5'b00011: begin alu = 12'h800; return 1; end
            5'b00100: begin alu = 12'h400; return 1; end
            5'b01110: begin alu = 12'h200; return 2; end
            5'b01111: begin alu = 12'h100; return 2; end
            5'b00101: begin alu = 12'h080; return 1; end
            5'b00110: begin alu = 12'h040; return 1; end
            5'b00111: begin alu = 12'h020; return 1; end
            5'b01000: begin alu = 12'h010; return 1; end
            5'b01001: begin alu = 12'h008; return 1; end
            5'b01010: begin alu = 12'h004; return 1; end
            5'b10000: begin alu = 12'h002; return 3; end
            5'b10001: begin alu = 12'h001; return 3; end
            5'b11010: return 4;
            default:  return 0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int k = 0; k < n; k++) begin
            step();
            check("rst_ctl", observed(), 64'd0);
            check("rst_cnt", {32'd0, instr_count}, 64'd0);
        end
        reset   = 1'b0;
        exp_cnt = 0;
        step();
    endtask

    // Entered with the DUT in T0 (sampled 1 time unit after the edge).
    task automatic run_instr(input logic [31:0] ir, input int rst_at, input int waits);
        cyc_t        q[$];
        cyc_t        c;
        logic [11:0] alu;
        int          kind;
        logic [3:0]  ra, rb, rc;
        ra   = ir[26:23];
        rb   = ir[22:19];
        rc   = ir[18:15];
        kind = kind_of(ir[31:27], alu);
        c = '{mk(0, 0, L_MAR | L_RZ, B_PC | B_INC, 0, 1), 1'($urandom_range(0, 1)), 1, 0};
        q.push_back(c);
        for (int w = 0; w < waits; w++) q.push_back('{mk(0, 0, L_MDR, B_READ, 0, 1), 0, 0, 0});
        q.push_back('{mk(0, 0, L_PC | L_MDR, B_RZ | B_READ, 0, 1), 1, 0, 0});
        q.push_back('{mk(0, 0, L_IR, B_MDR, 0, 1), 1'($urandom_range(0, 1)), 0, 1});
        case (kind)
            1, 2: begin
                q.push_back('{mk(0, oh(rb), L_RY, 0, 0, 1), 1'($urandom_range(0, 1)), 0, 0});
                q.push_back('{mk(0, oh(rc), L_RZ, 0, alu, 1), 1'($urandom_range(0, 1)), 0, 0});
                if (kind == 1)
                    q.push_back('{mk(oh(ra), 0, 0, B_RZ, 0, 1), 1'($urandom_range(0, 1)), 0, 0});
                else
                    q.push_back('{mk(0, 0, L_HILO, 0, 0, 1), 1'($urandom_range(0, 1)), 0, 0});
            end
            3: begin
                q.push_back('{mk(0, oh(rb), L_RZ, 0, alu, 1), 1'($urandom_range(0, 1)), 0, 0});
                q.push_back('{mk(oh(ra), 0, 0, B_RZ, 0, 1), 1'($urandom_range(0, 1)), 0, 0});
            end
            default: begin
                q.push_back('{mk(0, 0, 0, 0, 0, 1), 1'($urandom_range(0, 1)), 0, 0});
                if (kind == 4)
                    for (int h = 0; h < 20; h++)
                        q.push_back('{64'd0, 1'($urandom_range(0, 1)), 0, 0});
            end
        endcase
        IRVal = $urandom;
        foreach (q[i]) begin
`ifdef CU_MEM_WAIT_EN
            mem_ready = q[i].mr;
`endif
            #1;
            check("ctl", observed(), q[i].v);
            check("cnt", {32'd0, instr_count}, {32'd0, exp_cnt});
            if (q[i].fetch) exp_cnt = exp_cnt + 32'd1;
            if (q[i].load_ir) IRVal = ir;
            if (i == rst_at) begin
                do_reset(1);
                return;
            end
            step();
        end
        if (kind == 4) do_reset(1 + int'($urandom_range(0, 1)));
    endtask

    logic [4:0] ops [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                             5'b01001, 5'b01010, 5'b01110, 5'b01111, 5'b10000, 5'b10001,
                             5'b11001};

    initial begin
        logic [31:0] ir;
        int          ra_idx;
`ifdef CU_MEM_WAIT_EN
        wait_en   = 1'b1;
        mem_ready = 1'b1;
`else
        wait_en   = 1'b0;
`endif
        reset = 1'b1;
        IRVal = 32'd0;
        do_reset(2);

        run_instr(32'h4A920000, -1, 0);
        run_instr(32'h1A920000, -1, 0);
        run_instr(32'h72920000, -1, 0);
        run_instr(32'h82900000, -1, 0);
        run_instr(32'hC8000000, -1, 0);
        run_instr(32'hD0000000, -1, 0);
        run_instr(32'h1A920000, 4, 0);
        if (wait_en) run_instr(32'h4A920000, -1, 3);

        for (int n = 0; n < 400; n++) begin
            ir = $urandom;
            ra_idx = int'($urandom_range(0, 99));
            if (ra_idx < 3)       ir[31:27] = 5'b11010;
            else if (ra_idx < 85) ir[31:27] = ops[$urandom_range(0, 12)];
            run_instr(ir,
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1,
                      wait_en ? int'($urandom_range(0, 3)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
